rs_syndrome: RTL

Streaming Reed-Solomon syndrome calculator. It accepts one received codeword symbol per cycle, highest-degree coefficient first, and evaluates the received polynomial at ROOTS_NUM consecutive powers of alpha using Horner's rule, with one GF multiplier per root. It sits directly downstream of the channel/receive interface and feeds the key-equation solver. It presents a registered syndrome vector and a nonzero flag per codeword.

---
 rtl/gf_pkg.sv | 57 +++++
 rtl/gf_mult.sv | 24 ++
 rtl/rs_syndr_cell.sv | 31 +++
 rtl/rs_syndrome.sv | 61 ++++++
 4 files changed

// File: rtl/gf_pkg.sv
// GF(2^SYMB_WIDTH) definitions shared by the Reed-Solomon datapath blocks:
// field constants, symbol/syndrome types and alpha power table helpers.
package gf_pkg;

  localparam int unsigned SYMB_WIDTH  = 8;
  localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;
  localparam int unsigned FIELD_ORDER = (1 << SYMB_WIDTH) - 1;
  localparam int unsigned ROOTS_NUM   = 4;

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef symb_t [FIELD_ORDER-1:0] alpha_to_symb_t;
  typedef symb_t [ROOTS_NUM-1:0] syndr_vec_t;

  // Multiply by alpha (x), reducing by the primitive polynomial.
  function automatic symb_t mul_x(symb_t a);
    symb_t sh;
    sh = {a[SYMB_WIDTH-2:0], 1'b0};
    return a[SYMB_WIDTH-1] ? (sh ^ PRIM_POLY[SYMB_WIDTH-1:0]) : sh;
  endfunction

  function automatic alpha_to_symb_t alpha_to_symb_table();
    alpha_to_symb_t t;
    symb_t r;
    t = '0;
    r = symb_t'(1);
    // Shift entries in from the top so that entry k ends up holding alpha^k.
    for (int unsigned k = 0; k < FIELD_ORDER; k++) begin
      t = {r, t[FIELD_ORDER-1:1]};
      r = mul_x(r);
    end
    return t;
  endfunction

  function automatic symb_t alpha_to_symb(int unsigned exp);
    symb_t r;
    r = symb_t'(1);
    for (int unsigned k = 0; k < exp % FIELD_ORDER; k++) r = mul_x(r);
    return r;
  endfunction

  function automatic int unsigned symb_to_alpha(symb_t s);
    int unsigned res;
    symb_t r;
    res = 0;
    r = symb_t'(1);
    for (int unsigned k = 0; k < FIELD_ORDER; k++) begin
      if (r == s) res = k;
      r = mul_x(r);
    end
    return res;
  endfunction

  function automatic symb_t root_symb(int unsigned exp);
    return alpha_to_symb(exp % FIELD_ORDER);
  endfunction

endpackage

// File: rtl/gf_mult.sv
// Combinational GF(2^SYMB_WIDTH) multiplier (shift-and-add, polynomial basis).
module gf_mult
  import gf_pkg::*;
(
  input  symb_t a,
  input  symb_t b,
  output symb_t p
);

  symb_t sh;
  symb_t bb;

  always_comb begin
    p  = '0;
    sh = a;
    bb = b;
    for (int unsigned i = 0; i < SYMB_WIDTH; i++) begin
      if (bb[0]) p = p ^ sh;
      sh = mul_x(sh);
      bb = bb >> 1;
    end
  end

endmodule

// File: rtl/rs_syndr_cell.sv
// One Horner-rule syndrome accumulator evaluating the codeword at a fixed root.
module rs_syndr_cell
  import gf_pkg::*;
#(
  parameter symb_t ROOT = symb_t'(1)
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  first,
  input  symb_t s_data,
  output symb_t upd
);

  symb_t acc;
  symb_t prod;

  gf_mult u_mult (
    .a (acc),
    .b (ROOT),
    .p (prod)
  );

  assign upd = first ? s_data : (prod ^ s_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     acc <= '0;
    else if (en) acc <= upd;
  end

endmodule

// File: rtl/rs_syndrome.sv
// Streaming Reed-Solomon syndrome calculator: one symbol per cycle, highest
// degree first, registered syndrome vector with a nonzero flag per codeword.
module rs_syndrome
  import gf_pkg::*;
#(
  parameter int unsigned ROOTS_NUM = gf_pkg::ROOTS_NUM,
  parameter int unsigned FCR       = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_valid,
  input  logic [SYMB_WIDTH-1:0]                s_data,
  input  logic                                 s_last,
  output logic                                 s_ready,
  output logic                                 syndr_valid,
  output logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] syndr,
  output logic                                 syndr_nonzero,
  input  logic                                 syndr_ready
);

  logic                                 accept;
  logic                                 first;
  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] upd_vec;

  assign s_ready = !syndr_valid || syndr_ready;
  assign accept  = s_valid && s_ready;

  for (genvar j = 0; j < ROOTS_NUM; j++) begin : g_cell
    rs_syndr_cell #(
      .ROOT (root_symb(FCR + j))
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .en     (accept),
      .first  (first),
      .s_data (s_data),
      .upd    (upd_vec[j])
    );
  end

  // The beat after an accepted s_last always opens a new codeword.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         first <= 1'b1;
    else if (accept) first <= s_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syndr         <= '0;
      syndr_valid   <= 1'b0;
      syndr_nonzero <= 1'b0;
    end else if (accept && s_last) begin
      syndr         <= upd_vec;
      syndr_valid   <= 1'b1;
      syndr_nonzero <= |upd_vec;
    end else if (syndr_valid && syndr_ready) begin
      syndr_valid   <= 1'b0;
    end
  end

endmodule
